// File: rtl/fft_out_reorder.sv
// Reorders variable-size FFT frames (bit-reversed in, natural out) through a
// two-bank ping-pong RAM so one frame is written while the previous is read.
module fft_out_reorder #(
    parameter int WIDTH = 16,
    parameter int NMAX  = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     di_en,
    input  logic [WIDTH-1:0]         di_re,
    input  logic [WIDTH-1:0]         di_im,
    input  logic [1:0]               sel,
    output logic                     do_en,
    output logic [WIDTH-1:0]         do_re,
    output logic [WIDTH-1:0]         do_im,
    output logic [$clog2(NMAX)-1:0]  do_idx,
    output logic                     do_last,
    output logic                     ovf
);

    localparam int AW = $clog2(NMAX);
    localparam int NW = $clog2(AW + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    function automatic logic [AW-1:0] bitrev_n(input logic [AW-1:0] v, input logic [NW-1:0] nn);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r >> (NW'(AW) - nn);
    endfunction

    function automatic logic [AW-1:0] last_idx(input logic [NW-1:0] nn);
        return {AW{1'b1}} >> (NW'(AW) - nn);
    endfunction

    logic [2*WIDTH-1:0] mem [0:2*NMAX-1];

    logic [AW-1:0]          wcnt_q, wcnt_d;
    logic [NW-1:0]          wnn_q, wnn_d;
    logic                   wbank_q, wbank_d;
    logic                   wdrop_q, wdrop_d;
    logic [1:0]             full_q, full_d;
    logic [1:0][NW-1:0]     bank_nn_q, bank_nn_d;
    logic                   ovf_q, ovf_d;

    state_t                 state_q, state_d;
    logic                   rbank_q, rbank_d;
    logic [AW-1:0]          rcnt_q, rcnt_d;

    logic                   do_en_q, do_last_q;
    logic [WIDTH-1:0]       do_re_q, do_im_q;
    logic [AW-1:0]          do_idx_q;

    logic [NW-1:0]          sel_nn, wr_nn, rd_nn;
    logic                   wr_first, wr_drop, wr_last, wr_en, wr_done;
    logic [AW:0]            wr_addr, rd_addr;
    logic                   rd_en, rd_last, rd_done;

    // Size is only taken from sel on the first sample; later sel changes are ignored.
    always_comb begin
        case (sel)
            2'b10:   sel_nn = NW'(AW);
            2'b01:   sel_nn = NW'(AW - 1);
            2'b11:   sel_nn = NW'(AW - 2);
            default: sel_nn = NW'(AW - 3);
        endcase
    end

    assign wr_first = (wcnt_q == '0);
    assign wr_nn    = wr_first ? sel_nn : wnn_q;
    assign wr_drop  = wr_first ? full_q[wbank_q] : wdrop_q;
    assign wr_last  = (wcnt_q == last_idx(wr_nn));
    assign wr_en    = di_en && !wr_drop;
    assign wr_done  = wr_en && wr_last;
    assign wr_addr  = {wbank_q, bitrev_n(wcnt_q, wr_nn)};

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wcnt_d    = wcnt_q;
        wnn_d     = wnn_q;
        wdrop_d   = wdrop_q;
        wbank_d   = wbank_q;
        bank_nn_d = bank_nn_q;
        full_d    = full_q;
        ovf_d     = 1'b0;
        if (di_en) begin
            wcnt_d = wr_last ? '0 : wcnt_q + 1'b1;
            if (wr_first) begin
                wnn_d   = sel_nn;
                wdrop_d = wr_drop;
                ovf_d   = wr_drop;
            end
        end
        if (rd_done) full_d[rbank_q] = 1'b0;
        if (wr_done) begin
            full_d[wbank_q]    = 1'b1;
            bank_nn_d[wbank_q] = wr_nn;
            wbank_d            = ~wbank_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q    <= '0;
            wnn_q     <= '0;
            wdrop_q   <= 1'b0;
            wbank_q   <= 1'b0;
            bank_nn_q <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            wnn_q     <= wnn_d;
            wdrop_q   <= wdrop_d;
            wbank_q   <= wbank_d;
            bank_nn_q <= bank_nn_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: the sample RAM has no reset; its contents survive reset and it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= {di_re, di_im};
    end

    assign rd_nn   = bank_nn_q[rbank_q];
    assign rd_last = (rcnt_q == last_idx(rd_nn));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rbank_q <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Banks are read strictly in the order they were filled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (full_q[rbank_q]) state_d = S_RUN;
            S_RUN:  if (rd_last) state_d = full_q[~rbank_q] ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state_q == S_RUN);
        rd_done = rd_en && rd_last;
        rd_addr = {rbank_q, rcnt_q};
        rcnt_d  = (rd_en && !rd_last) ? rcnt_q + 1'b1 : '0;
        rbank_d = rd_done ? ~rbank_q : rbank_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            do_en_q   <= 1'b0;
            do_last_q <= 1'b0;
            do_re_q   <= '0;
            do_im_q   <= '0;
            do_idx_q  <= '0;
        end else begin
            do_en_q   <= rd_en;
            do_last_q <= rd_done;
            if (rd_en) begin
                {do_re_q, do_im_q} <= mem[rd_addr];
                do_idx_q           <= rcnt_q;
            end
        end
    end

    assign do_en   = do_en_q;
    assign do_last = do_last_q;
    assign do_re   = do_re_q;
    assign do_im   = do_im_q;
    assign do_idx  = do_idx_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: frames are driven bit-reversed and the
// natural-order samples they should produce are queued and matched on output.
module tb_fft_out_reorder;

    logic        clock;
    logic        reset;
    logic        di_en;
    logic [15:0] di_re, di_im;
    logic [1:0]  sel;
    logic        do_en;
    logic [15:0] do_re, do_im;
    logic [6:0]  do_idx;
    logic        do_last;
    logic        ovf;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   run_len = 0;
    int   max_run = 0;
    int   frames_out = 0;
    int   ovf_count = 0;

    fft_out_reorder #(.WIDTH(16), .NMAX(128)) dut (
        .clock   (clock),
        .reset   (reset),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .sel     (sel),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_idx  (do_idx),
        .do_last (do_last),
        .ovf     (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int bitrev(int v, int nn);
        int r = 0;
        for (int i = 0; i < nn; i++) if (v[i]) r |= (1 << (nn - 1 - i));
        return r;
    endfunction

    function automatic logic [1:0] sel_code(int nn);
        case (nn)
            7:       return 2'b10;
            6:       return 2'b01;
            5:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Output monitor: pops the scoreboard on every valid output sample.
    always @(negedge clock) begin
        exp_t e;
        if (do_en === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got idx=%0d re=%0d with nothing expected", do_idx, do_re);
            end else begin
                e = exp_q.pop_front();
                if ({do_re, do_im, do_idx, do_last} !== e) begin
                    errors++;
                    $display("FAIL sample: got re=%0d im=%0d idx=%0d last=%0b, want re=%0d im=%0d idx=%0d last=%0b",
                             do_re, do_im, do_idx, do_last, e.re, e.im, e.idx, e.last);
                end
            end
            if (do_last === 1'b1) frames_out++;
        end else begin
            run_len = 0;
        end
        if (ovf === 1'b1) ovf_count++;
    end

    task automatic send_frame(input int nn, input int base, input bit drop, input bit gaps,
                              input bit sel_toggle, input bit check_lat);
        int   n = 1 << nn;
        exp_t e;
        sel = sel_code(nn);
        if (!drop) begin
            for (int i = 0; i < n; i++) begin
                e.re   = 16'(base + i);
                e.im   = 16'(-(base + i));
                e.idx  = 7'(i);
                e.last = (i == n - 1);
                exp_q.push_back(e);
            end
        end
        for (int j = 0; j < n; j++) begin
            int bin = bitrev(j, nn);
            di_en = 1'b1;
            di_re = 16'(base + bin);
            di_im = 16'(-(base + bin));
            if (sel_toggle && j == n / 2) sel = sel ^ 2'b01;
            @(posedge clock); #1;
            if (j == 0) begin
                checks++;
                if (ovf !== drop) begin
                    errors++;
                    $display("FAIL ovf_first_sample: got %b, want %b", ovf, drop);
                end
            end
            if (gaps && j != n - 1) begin
                di_en = 1'b0;
                @(posedge clock); #1;
            end
        end
        di_en = 1'b0;
        if (check_lat) begin
            checks++;
            if (do_en !== 1'b0) begin
                errors++;
                $display("FAIL latency_t0: got do_en=%b, want 0", do_en);
            end
            @(posedge clock); #1;
            checks++;
            if (do_en !== 1'b0) begin
                errors++;
                $display("FAIL latency_t1: got do_en=%b, want 0", do_en);
            end
            @(posedge clock); #1;
            checks++;
            if (do_en !== 1'b1) begin
                errors++;
                $display("FAIL latency_t2: got do_en=%b, want 1", do_en);
            end
        end
    endtask

    task automatic idle(input int cycles);
        di_en = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clock);
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d samples still pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        sel   = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({do_en, do_last, ovf, do_idx, do_re, do_im} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b last=%b ovf=%b idx=%0d re=%0d im=%0d, want all 0",
                     do_en, do_last, ovf, do_idx, do_re, do_im);
        end
        reset = 1'b0;
        idle(2);
        checks++;
        if (do_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got do_en=%b, want 0", do_en);
        end
    endtask

    task automatic test_basic16();
        send_frame(4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("basic16", 100);
    endtask

    task automatic test_back_to_back();
        int f0 = frames_out;
        int o0 = ovf_count;
        max_run = 0;
        send_frame(7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(7, 128, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain("b2b", 400);
        checks++;
        if (max_run != 256) begin
            errors++;
            $display("FAIL b2b_contiguous: got longest do_en run %0d, want 256", max_run);
        end
        checks++;
        if (frames_out - f0 != 2 || ovf_count != o0) begin
            errors++;
            $display("FAIL b2b_frames: got frames=%0d ovf=%0d, want frames=2 ovf=0", frames_out - f0, ovf_count - o0);
        end
    endtask

    task automatic test_sizes();
        int f0 = frames_out;
        send_frame(7, 100, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(200);
        send_frame(6, 300, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(200);
        send_frame(5, 500, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(200);
        send_frame(4, 700, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain("sizes", 300);
        checks++;
        if (frames_out - f0 != 4) begin
            errors++;
            $display("FAIL sizes_frames: got %0d frames, want 4", frames_out - f0);
        end
    endtask

    task automatic test_overflow();
        int f0 = frames_out;
        int o0 = ovf_count;
        send_frame(7, 1000, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4, 2000, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4, 3000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("overflow", 400);
        checks++;
        if (ovf_count - o0 != 1) begin
            errors++;
            $display("FAIL overflow_pulses: got %0d ovf pulses, want 1", ovf_count - o0);
        end
        checks++;
        if (frames_out - f0 != 2) begin
            errors++;
            $display("FAIL overflow_frames: got %0d frames, want 2", frames_out - f0);
        end
        // The dropped frame must not have toggled the bank: a new frame still flows.
        send_frame(4, 4000, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("after_overflow", 100);
    endtask

    task automatic test_gaps();
        send_frame(5, 600, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain("gaps", 100);
    endtask

    task automatic test_reset_mid_output();
        bit found = 1'b0;
        send_frame(6, 800, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clock);
            if (do_en === 1'b1 && do_idx === 7'd40) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach: got no output sample 40, want one");
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (do_en !== 1'b0 || do_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_do_en: got do_en=%b do_last=%b, want 0 0", do_en, do_last);
        end
        exp_q.delete();
        idle(3);
        send_frame(4, 900, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("midreset", 100);
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_back_to_back();
        test_sizes();
        test_overflow();
        test_gaps();
        test_reset_mid_output();
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
